xor_1: RTL and testbench

XOR_1 -- requirements
Module: xor_1

---
 rtl/xor_1.sv | 127 ++++++++++++
 tb/tb_xor_1.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/xor_1.sv
`default_nettype none
// ============================================================================
//  Module   : xor_1
//  Purpose  : Bitwise XOR of two operands with a combinational result, a
//             registered result qualified by in_valid, registered reduction
//             parity of the captured result, and an optional saturating
//             count of valid captures whose operands differed.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH     operand/result width in bits (1..64)
//    CNT_W     mismatch-counter width in bits (2..32)
//  Ports
//    clk       in   1      rising-edge clock
//    rst_n     in   1      synchronous active-low reset
//    a         in   WIDTH  first operand
//    b         in   WIDTH  second operand
//    in_valid  in   1      qualifies a/b for capture
//    clr_cnt   in   1      synchronous clear of diff_cnt (wins over increment)
//    c         out  WIDTH  registered a ^ b (holds when in_valid=0)
//    c_comb    out  WIDTH  combinational a ^ b, independent of reset
//    out_valid out  1      in_valid delayed by one clock
//    parity    out  1      registered reduction-XOR of the captured result
//    diff_cnt  out  CNT_W  saturating count of valid captures with a != b
//  Configuration
//    XOR1_STATS_EN  when defined the mismatch counter is built; otherwise
//                   diff_cnt is tied to zero and clr_cnt is ignored.
// ============================================================================
module xor_1 #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] c_comb,
   output logic             out_valid,
   output logic             parity,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] diff_cnt
);

   // Shared XOR term: drives c_comb directly and feeds the capture register.
   logic [WIDTH-1:0] xor_res;
   assign xor_res = a ^ b;
   assign c_comb  = xor_res;

   // -------------------------------------------------------------------------
   // Result / parity / valid pipeline stage
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] c_q,      c_d;
   logic             parity_q, parity_d;
   logic             valid_q,  valid_d;

   // Capture only when qualified, so undriven operands while idle never
   // reach the registers.
   always_comb begin
      c_d      = c_q;
      parity_d = parity_q;
      valid_d  = in_valid;
      if (in_valid) begin
         c_d      = xor_res;
         parity_d = ^xor_res;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         c_q      <= '0;
         parity_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         c_q      <= c_d;
         parity_q <= parity_d;
         valid_q  <= valid_d;
      end
   end

   assign c         = c_q;
   assign parity    = parity_q;
   assign out_valid = valid_q;

   // -------------------------------------------------------------------------
   // Mismatch statistics
   // -------------------------------------------------------------------------
`ifdef XOR1_STATS_EN
   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mismatch;

   // in_valid gates the compare so X/Z operands while idle cannot count.
   assign mismatch = in_valid && (a != b);

   // Clear has priority; the counter sticks at all-ones instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_cnt) begin
         cnt_d = '0;
      end else if (mismatch && (cnt_q != c_cnt_max)) begin
         cnt_d = cnt_q + c_cnt_one;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign diff_cnt = cnt_q;
`else
   // Counter compiled out: output held at zero, clear input deliberately
   // left unconnected.
   logic unused_clr_cnt;
   assign unused_clr_cnt = clr_cnt;
   assign diff_cnt       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xor_1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xor_1
//  Purpose  : Directed self-checking bench for xor_1. A 1-bit instance with a
//             2-bit counter covers the truth table, hold, reset and counter
//             saturation; an 8-bit instance covers wide operands and parity.
//             Counter expectations follow XOR1_STATS_EN (zero when undefined).
//  Revision : 1.0  initial release
// ============================================================================
module tb_xor_1;

`ifdef XOR1_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        clr_cnt;
   logic        a1, b1;
   logic        c1, c_comb1, ov1, par1;
   logic [1:0]  cnt1;
   logic [7:0]  a8, b8, c8, c_comb8;
   logic        ov8, par8;
   logic [15:0] cnt8;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   xor_1 #(.WIDTH(1), .CNT_W(2)) u_w1 (
      .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(in_valid),
      .c(c1), .c_comb(c_comb1), .out_valid(ov1), .parity(par1),
      .clr_cnt(clr_cnt), .diff_cnt(cnt1)
   );

   xor_1 #(.WIDTH(8), .CNT_W(16)) u_w8 (
      .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(in_valid),
      .c(c8), .c_comb(c_comb8), .out_valid(ov8), .parity(par8),
      .clr_cnt(clr_cnt), .diff_cnt(cnt8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected counter value given the stats build option.
   function automatic logic [63:0] ec(input int v);
      return STATS ? 64'(v) : 64'd0;
   endfunction

   logic tt_exp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
   int   tt_cnt [4] = '{0, 1, 2, 2};
   int   sat    [5] = '{1, 2, 3, 3, 3};

   initial begin
      rst_n = 1'b0; in_valid = 1'b1; clr_cnt = 1'b1;
      a1 = 1'b1; b1 = 1'b0; a8 = 8'hFF; b8 = 8'h00;
      step(); step();
      check("rst_c1",    c1,   0);
      check("rst_par1",  par1, 0);
      check("rst_ov1",   ov1,  0);
      check("rst_cnt1",  cnt1, 0);
      check("rst_c8",    c8,   0);
      check("rst_ccomb", c_comb1, 1);

      // Truth table on the 1-bit instance.
      rst_n = 1'b1; clr_cnt = 1'b0; in_valid = 1'b1; a8 = 8'h00; b8 = 8'h00;
      for (int i = 0; i < 4; i++) begin
         a1 = i[1]; b1 = i[0];
         #1;
         check($sformatf("tt_comb%0d", i), c_comb1, tt_exp[i]);
         step();
         check($sformatf("tt_c%0d", i),   c1,   tt_exp[i]);
         check($sformatf("tt_par%0d", i), par1, tt_exp[i]);
         check($sformatf("tt_ov%0d", i),  ov1,  1);
         check($sformatf("tt_cnt%0d", i), cnt1, ec(tt_cnt[i]));
      end

      // Hold: capture 01, then idle with 11 and then with X on a.
      a1 = 1'b0; b1 = 1'b1;
      step();
      check("hold_cap_c", c1, 1);
      check("hold_cnt3",  cnt1, ec(3));
      in_valid = 1'b0; a1 = 1'b1; b1 = 1'b1;
      #1;
      check("hold_comb", c_comb1, 0);
      step();
      check("hold_c",   c1,   1);
      check("hold_ov",  ov1,  0);
      check("hold_par", par1, 1);
      a1 = 1'bx;
      step();
      check("x_c",   c1,   1);
      check("x_par", par1, 1);
      check("x_cnt", cnt1, ec(3));

      // Reset mid-stream with a valid capture pending.
      a1 = 1'b1; b1 = 1'b0; in_valid = 1'b1; rst_n = 1'b0;
      step();
      check("mrst_c",    c1,   0);
      check("mrst_par",  par1, 0);
      check("mrst_ov",   ov1,  0);
      check("mrst_cnt",  cnt1, 0);
      check("mrst_comb", c_comb1, 1);
      rst_n = 1'b1;
      step();
      check("post_c",   c1,   1);
      check("post_ov",  ov1,  1);
      check("post_cnt", cnt1, ec(1));

      // Wide operands on the 8-bit instance.
      a1 = 1'b0; b1 = 1'b0; a8 = 8'hA5; b8 = 8'h0F;
      #1;
      check("w_comb", c_comb8, 8'hAA);
      step();
      check("w_c",   c8,   8'hAA);
      check("w_par", par8, 0);
      check("w_cnt", cnt8, ec(1));
      a8 = 8'h01; b8 = 8'h00;
      step();
      check("w_c2",   c8,   8'h01);
      check("w_par2", par8, 1);
      check("w_cnt2", cnt8, ec(2));

      // Saturation of the 2-bit counter, then clear racing an increment.
      a8 = 8'h33; b8 = 8'h33; in_valid = 1'b0; clr_cnt = 1'b1;
      step();
      check("clr_idle1", cnt1, 0);
      check("clr_idle8", cnt8, 0);
      clr_cnt = 1'b0; in_valid = 1'b1; a1 = 1'b1; b1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("sat%0d", i), cnt1, ec(sat[i]));
      end
      clr_cnt = 1'b1;
      step();
      check("clr_prio", cnt1, 0);
      clr_cnt = 1'b0;
      step();
      check("after_clr", cnt1, ec(1));
      check("w_cnt_eq",  cnt8, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
